// File: rtl/knn_feeder.sv
// Host-side sequencer for the knn core: loads one test point per solver, streams the
// training set, then raises DONE and walks every solver's neighbour list onto a result stream.
module knn_feeder #(
    parameter int HW_K      = 10,
    parameter int N_SOLVERS = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] train_base,
    input  logic [ADDR_W-1:0] test_base,
    input  logic [CNT_W-1:0]  n_train,
    output logic              busy,
    output logic              done_o,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              knn_valid,
    output logic              knn_done,
    output logic [DATA_W-1:0] knn_data_1,
    output logic [DATA_W-1:0] knn_data_2,
    output logic [15:0]       knn_solver_sel,
    output logic [15:0]       knn_sel,
    input  logic [15:0]       knn_data_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_data,
    output logic [15:0]       res_solver,
    output logic [15:0]       res_idx
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STREAM, S_FLUSH, S_CAP, S_HOLD, S_FIN
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] train_base_reg, test_base_reg;
    logic [CNT_W-1:0]  n_train_reg, cnt_reg;
    logic              ld_d1_reg, st_d1_reg;
    logic [15:0]       ld_idx_d1_reg;
    logic              knn_valid_reg, knn_done_reg;
    logic [DATA_W-1:0] knn_data_1_reg, knn_data_2_reg;
    logic [15:0]       knn_solver_sel_reg, knn_sel_reg;
    logic              res_valid_reg;
    logic [15:0]       res_data_reg, res_solver_reg, res_idx_reg;

    logic load_last, stream_last, drain_last, pipe_empty, accept;

    assign load_last   = (cnt_reg == CNT_W'(N_SOLVERS - 1));
    assign stream_last = (cnt_reg == n_train_reg - CNT_W'(1));
    assign drain_last  = (knn_solver_sel_reg == 16'(N_SOLVERS - 1)) && (knn_sel_reg == 16'(HW_K - 1));
    assign pipe_empty  = !ld_d1_reg && !st_d1_reg;
    assign accept      = res_valid_reg && res_ready;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        mem_en     = 1'b0;
        mem_addr   = '0;
        unique case (state_reg)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD: begin
                mem_en   = 1'b1;
                mem_addr = test_base_reg + ADDR_W'(cnt_reg);
                if (load_last) state_next = (n_train_reg == '0) ? S_FLUSH : S_STREAM;
            end
            S_STREAM: begin
                mem_en   = 1'b1;
                mem_addr = train_base_reg + ADDR_W'(cnt_reg);
                if (stream_last) state_next = S_FLUSH;
            end
            // Wait for the last in-flight memory word to reach the core before DONE.
            S_FLUSH:  if (pipe_empty) state_next = S_CAP;
            S_CAP:    state_next = S_HOLD;
            S_HOLD:   if (accept) state_next = drain_last ? S_FIN : S_CAP;
            S_FIN:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            train_base_reg     <= '0;
            test_base_reg      <= '0;
            n_train_reg        <= '0;
            cnt_reg            <= '0;
            ld_d1_reg          <= 1'b0;
            st_d1_reg          <= 1'b0;
            ld_idx_d1_reg      <= '0;
            knn_valid_reg      <= 1'b0;
            knn_done_reg       <= 1'b1;
            knn_data_1_reg     <= '0;
            knn_data_2_reg     <= '0;
            knn_solver_sel_reg <= '0;
            knn_sel_reg        <= '0;
            res_valid_reg      <= 1'b0;
            res_data_reg       <= '0;
            res_solver_reg     <= '0;
            res_idx_reg        <= '0;
        end else begin
            // Tags travel alongside the one-cycle memory latency.
            ld_d1_reg     <= (state_reg == S_LOAD);
            st_d1_reg     <= (state_reg == S_STREAM);
            ld_idx_d1_reg <= 16'(cnt_reg);
            knn_valid_reg <= st_d1_reg;
            if (ld_d1_reg) begin
                knn_data_1_reg     <= mem_rdata;
                knn_solver_sel_reg <= ld_idx_d1_reg;
            end
            if (st_d1_reg) knn_data_2_reg <= mem_rdata;

            unique case (state_reg)
                S_IDLE: begin
                    cnt_reg <= '0;
                    if (start) begin
                        train_base_reg <= train_base;
                        test_base_reg  <= test_base;
                        n_train_reg    <= n_train;
                        knn_done_reg   <= 1'b0;
                    end
                end
                S_LOAD:   cnt_reg <= load_last ? '0 : cnt_reg + CNT_W'(1);
                S_STREAM: cnt_reg <= cnt_reg + CNT_W'(1);
                S_FLUSH: begin
                    if (pipe_empty) begin
                        knn_done_reg       <= 1'b1;
                        knn_solver_sel_reg <= '0;
                        knn_sel_reg        <= '0;
                    end
                end
                S_CAP: begin
                    res_valid_reg  <= 1'b1;
                    res_data_reg   <= knn_data_out;
                    res_solver_reg <= knn_solver_sel_reg;
                    res_idx_reg    <= knn_sel_reg;
                end
                S_HOLD: begin
                    if (accept) begin
                        res_valid_reg <= 1'b0;
                        if (!drain_last) begin
                            if (knn_sel_reg == 16'(HW_K - 1)) begin
                                knn_sel_reg        <= '0;
                                knn_solver_sel_reg <= knn_solver_sel_reg + 16'd1;
                            end else begin
                                knn_sel_reg <= knn_sel_reg + 16'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy           = (state_reg != S_IDLE);
    assign done_o         = (state_reg == S_FIN);
    assign knn_valid      = knn_valid_reg;
    assign knn_done       = knn_done_reg;
    assign knn_data_1     = knn_data_1_reg;
    assign knn_data_2     = knn_data_2_reg;
    assign knn_solver_sel = knn_solver_sel_reg;
    assign knn_sel        = knn_sel_reg;
    assign res_valid      = res_valid_reg;
    assign res_data       = res_data_reg;
    assign res_solver     = res_solver_reg;
    assign res_idx        = res_idx_reg;
endmodule

// File: doc/knn_feeder.md
Name: knn_feeder

Overview:
Host-side sequencer that drives the knn accelerator core's streaming interface; it is the initiator of the protocol the core responds to. From a start command it:
- fetches test points and training points from a single-port, 1-cycle-latency data memory;
- loads one test point into each solver;
- streams the training set with valid beats;
- asserts DONE and reads back every solver's K nearest labels through SOLVER_SEL/SEL.
Results leave on a valid/ready stream toward the CPU-side register file or DMA.

Parameters:
HW_K, 10, neighbours held per solver (SEL range 0..HW_K-1)
N_SOLVERS, 4, number of parallel solvers (SOLVER_SEL range 0..N_SOLVERS-1)
DATA_W, 32, point word width (DATA_1/DATA_2)
ADDR_W, 16, memory address width
CNT_W, 16, training-count width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle command pulse, honoured only in IDLE
train_base  in  ADDR_W  first training-point address, latched on start
test_base  in  ADDR_W  first test-point address, latched on start
n_train  in  CNT_W  number of training points, latched on start
busy  out  1  high from the cycle after an accepted start until FIN exits
done_o  out  1  one-cycle pulse in FIN
mem_en  out  1  memory read enable
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  read data, valid the cycle after mem_en
knn_valid  out  1  to core valid
knn_done  out  1  to core DONE
knn_data_1  out  DATA_W  to core DATA_1 (test point)
knn_data_2  out  DATA_W  to core DATA_2 (training point)
knn_solver_sel  out  16  to core SOLVER_SEL
knn_sel  out  16  to core SEL
knn_data_out  in  16  from core DATA_OUT (combinational on SEL/SOLVER_SEL)
res_valid  out  1  result beat valid
res_ready  in  1  result beat accepted when res_valid and res_ready are both high
res_data  out  16  result value
res_solver  out  16  solver index of the beat
res_idx  out  16  neighbour index of the beat

Behaviour:
- Reset values: knn_done=1; all other outputs 0; state IDLE.
- rst has priority at any time, including mid-operation: return to IDLE, drop any pending result, force res_valid=0.
- All knn_* and res_* outputs are registered.
- Pipeline: address issued (mem_en=1) in cycle t → mem_rdata in t+1 → registered onto knn_data_1/knn_data_2 in t+2, with the matching strobe/selector.
- States:
  - IDLE: busy=0. start=1 latches bases and n_train and moves to LOAD.
  - LOAD:
    - knn_done=0 from the first LOAD cycle.
    - Issue test_base+c for c=0..N_SOLVERS-1 on consecutive cycles.
    - Core sees knn_solver_sel=c and knn_data_1=word c together for exactly one cycle each, with knn_valid=0.
    - After the last issue, go to STREAM.
    - knn_data_1 holds its final value afterwards.
  - STREAM:
    - Issue train_base+j for j=0..n_train-1 on consecutive cycles, no bubbles.
    - knn_valid=1 for exactly n_train contiguous cycles, knn_data_2=word j on beat j.
    - n_train=0: zero valid beats, go directly to DRAIN.
    - Go to DRAIN once the last beat has been presented. knn_done rises the cycle after the last valid beat, never in the same cycle.
  - DRAIN:
    - knn_done=1, knn_valid=0.
    - Walk s=0..N_SOLVERS-1 outer, k=0..HW_K-1 inner.
    - Drive knn_solver_sel=s, knn_sel=k for one cycle, then capture knn_data_out into res_data with res_solver=s, res_idx=k, res_valid=1.
    - res_* hold stable while res_valid=1 and res_ready=0.
    - On acceptance, advance the selectors. Beats are back-to-back when res_ready stays high: 1 beat/2 cycles minimum is acceptable; 1 beat/cycle is allowed.
    - After beat N_SOLVERS*HW_K-1 is accepted, go to FIN.
  - FIN: done_o=1 for one cycle, then IDLE. busy falls with the IDLE entry. knn_done stays 1.
- start outside IDLE is ignored, with no effect on latched values.
- Address arithmetic is modulo 2^ADDR_W; base+index wraps silently.
- mem_en=0 whenever no address is issued.
- Counters must not overflow for n_train up to 2^CNT_W-1.

Test Plan:
1. Reset release: outputs follow reset values (knn_done=1, all others 0).
2. Basic run: N_SOLVERS=4, HW_K=10, test words 200..203, n_train=33 with training words 3,6,…,99, res_ready=1 → core sees solver c loaded with 200+c, 33 contiguous valid beats carrying 3..99, knn_done rising the cycle after the last beat, 40 result beats ordered (s,k) with res_data equal to the core model, then done_o pulse.
3. n_train=0 → no knn_valid beats; knn_done returns to 1 right after LOAD; 40 result beats still produced.
4. Backpressure: res_ready toggling 1-in-3 cycles → no beat lost or duplicated, res_* stable while stalled.
5. start pulsed during STREAM with different bases → ignored; results match the original command.
6. rst asserted mid-STREAM (beat 10 of 33), then a fresh start → immediate IDLE with knn_done=1 and res_valid=0; second run completes correctly. Also test_base=0xFFFE with N_SOLVERS=4 → addresses FFFE, FFFF, 0000, 0001.
